// File: rtl/axi_burst_selftest.sv
// AXI4 write-then-read burst self-test master: writes an address-derived
// pattern over one INCR burst, reads it back and counts mismatching beats.
module axi_burst_selftest #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] SEED           = 64'hA5A5_5A5A_0F0F_F0F0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [7:0]                len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [15:0]               err_cnt_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] aw_addr_o,
  output logic [7:0]                aw_len_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] w_data_o,
  output logic                      w_last_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
  output logic [7:0]                ar_len_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                beat_q, beat_d;
  logic [15:0]               err_q, err_d;
  logic                      pass_q, pass_d;

  logic [AXI_ADDR_WIDTH-1:0] beat_addr;
  logic [AXI_DATA_WIDTH-1:0] pattern;
  logic                      last_beat;
  logic [15:0]               err_sat;

  // One beat counter serves both the write and the read burst, so the
  // expected pattern is the same expression in both phases.
  always_comb begin
    beat_addr = addr_q + AXI_ADDR_WIDTH'({beat_q, 3'b000});
    pattern   = AXI_DATA_WIDTH'(64'(beat_addr) ^ SEED);
    last_beat = (beat_q == len_q);
    err_sat   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~AXI_ADDR_WIDTH'(7);
          len_d   = len_i;
          beat_d  = 8'd0;
          err_d   = 16'd0;
          pass_d  = 1'b0;
          state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (aw_ready_i) begin
          beat_d  = 8'd0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_ready_i) begin
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (b_valid_i) begin
          if (b_resp_i != 2'b00) begin
            err_d = err_sat;
          end
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (ar_ready_i) begin
          beat_d  = 8'd0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_valid_i) begin
          // Data, response and last-flag faults on one beat count once.
          if ((r_data_i != pattern) || (r_resp_i != 2'b00) ||
              (r_last_i != last_beat)) begin
            err_d = err_sat;
          end
          if (last_beat) begin
            pass_d  = (err_d == 16'd0);
            state_d = DONE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      err_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // Valids and readies decode only the registered state, so no ready input
  // can reach a valid output combinationally; payloads read zero when idle.
  always_comb begin
    busy_o     = (state_q != IDLE) && (state_q != DONE);
    done_o     = (state_q == DONE);
    pass_o     = pass_q;
    err_cnt_o  = err_q;
    aw_valid_o = (state_q == WR_ADDR);
    aw_addr_o  = aw_valid_o ? addr_q : '0;
    aw_len_o   = aw_valid_o ? len_q : 8'd0;
    w_valid_o  = (state_q == WR_DATA);
    w_data_o   = w_valid_o ? pattern : '0;
    w_last_o   = w_valid_o && last_beat;
    b_ready_o  = (state_q == WR_RESP);
    ar_valid_o = (state_q == RD_ADDR);
    ar_addr_o  = ar_valid_o ? addr_q : '0;
    ar_len_o   = ar_valid_o ? len_q : 8'd0;
    r_ready_o  = (state_q == RD_DATA);
  end

endmodule

// File: tb/tb_axi_burst_selftest.sv
// Randomized scoreboard bench for axi_burst_selftest with a behavioural
// AXI slave memory that can stall, corrupt read data and return SLVERR.
module tb_axi_burst_selftest;

  localparam logic [63:0] SEED = 64'hA5A5_5A5A_0F0F_F0F0;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] base_addr_i;
  logic [7:0]  len_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_cnt_o;
  logic        aw_valid_o, aw_ready_i;
  logic [63:0] aw_addr_o;
  logic [7:0]  aw_len_o;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [63:0] w_data_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [7:0]  ar_len_o;
  logic        r_valid_i, r_ready_o, r_last_i;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;

  axi_burst_selftest dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_data_o(w_data_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int w_hs_cnt = 0;

  logic [71:0] exp_aw_q[$];
  logic [71:0] exp_ar_q[$];
  logic [64:0] exp_w_q[$];
  logic [16:0] exp_res_q[$];

  int   stall_en = 0;
  int   corrupt_beat = -1;
  logic bad_bresp = 1'b0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] wr_addr;
  int          wr_cnt;
  logic        b_pending;
  logic [66:0] rd_q[$];

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rnd_ready();
    return (stall_en == 0) || ($urandom_range(0, 2) == 0);
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({busy_o, done_o, pass_o, err_cnt_o, aw_valid_o, aw_addr_o,
                 aw_len_o, w_valid_o, w_data_o, w_last_o, b_ready_o,
                 ar_valid_o, ar_addr_o, ar_len_o, r_ready_o});
  endfunction

  // Slave memory: drives inputs on the falling edge, then books the
  // handshakes the next rising edge will see.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
      b_valid_i = 1'b0; b_resp_i = 2'b00;
      r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0;
      b_pending = 1'b0; wr_cnt = 0; wr_addr = '0;
      rd_q.delete();
    end else begin
      aw_ready_i = rnd_ready();
      w_ready_i  = rnd_ready();
      ar_ready_i = rnd_ready();
      b_valid_i  = b_pending && rnd_ready();
      b_resp_i   = bad_bresp ? 2'b10 : 2'b00;
      if (rd_q.size() > 0 && rnd_ready()) begin
        r_valid_i = 1'b1;
        {r_data_i, r_resp_i, r_last_i} = rd_q[0];
      end else begin
        r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00; r_last_i = 1'b0;
      end
      #1;
      if (aw_valid_o && aw_ready_i) begin
        wr_addr = aw_addr_o;
        wr_cnt  = 0;
      end
      if (w_valid_o && w_ready_i) begin
        mem[wr_addr + 64'(wr_cnt) * 64'd8] = w_data_o;
        wr_cnt++;
        if (w_last_o) b_pending = 1'b1;
      end
      if (b_valid_i && b_ready_o) b_pending = 1'b0;
      if (ar_valid_o && ar_ready_i) begin
        for (int k = 0; k <= int'(ar_len_o); k++) begin
          logic [63:0] a;
          logic [63:0] d;
          a = ar_addr_o + 64'(k) * 64'd8;
          d = mem.exists(a) ? mem[a] : 64'd0;
          if (k == corrupt_beat) d[0] = ~d[0];
          rd_q.push_back({d, 2'b00, (k == int'(ar_len_o))});
        end
      end
      if (r_valid_i && r_ready_o) void'(rd_q.pop_front());
    end
  end

  logic        aw_stall_p = 1'b0, w_stall_p = 1'b0, ar_stall_p = 1'b0;
  logic [71:0] aw_p, ar_p;
  logic [64:0] w_p;

  // Monitor: pops expectations on every handshake and done pulse.
  always @(negedge clk_i) begin
    #2;
    if (!rst_ni) begin
      aw_stall_p = 1'b0; w_stall_p = 1'b0; ar_stall_p = 1'b0;
    end else begin
      if (aw_stall_p) checkOutput("aw_stable", 256'({aw_valid_o, aw_addr_o, aw_len_o}), 256'({1'b1, aw_p}));
      if (w_stall_p)  checkOutput("w_stable", 256'({w_valid_o, w_data_o, w_last_o}), 256'({1'b1, w_p}));
      if (ar_stall_p) checkOutput("ar_stable", 256'({ar_valid_o, ar_addr_o, ar_len_o}), 256'({1'b1, ar_p}));
      aw_stall_p = aw_valid_o && !aw_ready_i; aw_p = {aw_addr_o, aw_len_o};
      w_stall_p  = w_valid_o && !w_ready_i;   w_p  = {w_data_o, w_last_o};
      ar_stall_p = ar_valid_o && !ar_ready_i; ar_p = {ar_addr_o, ar_len_o};

      if (aw_valid_o && aw_ready_i) begin
        checkOutput("aw_expected", 256'(exp_aw_q.size() > 0), 256'(1));
        if (exp_aw_q.size() > 0)
          checkOutput("aw_payload", 256'({aw_addr_o, aw_len_o}), 256'(exp_aw_q.pop_front()));
      end
      if (w_valid_o && w_ready_i) begin
        w_hs_cnt++;
        checkOutput("w_expected", 256'(exp_w_q.size() > 0), 256'(1));
        if (exp_w_q.size() > 0)
          checkOutput("w_beat", 256'({w_data_o, w_last_o}), 256'(exp_w_q.pop_front()));
      end
      if (ar_valid_o && ar_ready_i) begin
        checkOutput("ar_expected", 256'(exp_ar_q.size() > 0), 256'(1));
        if (exp_ar_q.size() > 0)
          checkOutput("ar_payload", 256'({ar_addr_o, ar_len_o}), 256'(exp_ar_q.pop_front()));
      end
      if (done_o) begin
        done_cnt++;
        checkOutput("done_expected", 256'(exp_res_q.size() > 0), 256'(1));
        if (exp_res_q.size() > 0)
          checkOutput("done_result", 256'({busy_o, pass_o, err_cnt_o}), 256'({1'b0, exp_res_q.pop_front()}));
      end
    end
  end

  task automatic push_expected(input logic [63:0] base, input logic [7:0] len,
                               input int exp_err);
    logic [63:0] a;
    a = base & ~64'h7;
    exp_aw_q.push_back({a, len});
    for (int k = 0; k <= int'(len); k++)
      exp_w_q.push_back({(a + 64'(k) * 64'd8) ^ SEED, (k == int'(len))});
    exp_ar_q.push_back({a, len});
    exp_res_q.push_back({(exp_err == 0), 16'(exp_err)});
  endtask

  task automatic issue_start(input logic [63:0] base, input logic [7:0] len);
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = base; len_i = len;
    @(negedge clk_i);
    start_i = 1'b0; base_addr_i = {$urandom, $urandom}; len_i = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [63:0] base, input logic [7:0] len,
                               input int stall, input int corrupt,
                               input logic bad_b, input logic extra_start);
    int exp_err;
    int d0;
    int n;
    exp_err = (bad_b ? 1 : 0) + ((corrupt >= 0 && corrupt <= int'(len)) ? 1 : 0);
    push_expected(base, len, exp_err);
    stall_en = stall; corrupt_beat = corrupt; bad_bresp = bad_b;
    d0 = done_cnt;
    issue_start(base, len);
    if (extra_start) begin
      repeat (2) @(negedge clk_i);
      checkOutput("busy_at_restart", 256'(busy_o), 256'(1));
      issue_start({$urandom, $urandom}, 8'($urandom));
    end
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk_i); #3; n++;
    end
    checkOutput("done_seen", 256'(done_cnt != d0), 256'(1));
    repeat (6) @(negedge clk_i);
    #3;
    checkOutput("done_pulses", 256'(done_cnt - d0), 256'(1));
    checkOutput("held_result", 256'({busy_o, pass_o, err_cnt_o}),
                256'({1'b0, (exp_err == 0), 16'(exp_err)}));
    checkOutput("scoreboard_drained", 256'(exp_aw_q.size() + exp_w_q.size() +
                exp_ar_q.size() + exp_res_q.size()), 256'(0));
  endtask

  task automatic reset_mid_burst();
    int w0;
    int d0;
    int n;
    push_expected(64'h8000_0000, 8'd3, 0);
    stall_en = 0; corrupt_beat = -1; bad_bresp = 1'b0;
    w0 = w_hs_cnt; d0 = done_cnt;
    issue_start(64'h8000_0000, 8'd3);
    n = 0;
    while (w_hs_cnt < w0 + 1 && n < 200) begin
      @(negedge clk_i); #3; n++;
    end
    checkOutput("first_w_beat_seen", 256'(w_hs_cnt >= w0 + 1), 256'(1));
    @(negedge clk_i);
    #3;
    checkOutput("pre_reset_beat1", 256'({w_valid_o, w_data_o}),
                256'({1'b1, (64'h8000_0008 ^ SEED)}));
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_immediate", all_outs(), 256'(0));
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_res_q.delete();
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("reset_held", all_outs(), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    #3;
    checkOutput("no_done_after_reset", 256'({done_cnt - d0, all_outs()}), 256'(0));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = 8'd0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_state", all_outs(), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    applyStimulus(64'h8000_0000, 8'd3, 0, -1, 1'b0, 1'b0);
    applyStimulus(64'h8000_0000, 8'd3, 1, -1, 1'b0, 1'b0);
    applyStimulus(64'h8000_0000, 8'd3, 0, 2, 1'b1, 1'b0);
    applyStimulus(64'h8000_0007, 8'd0, 0, -1, 1'b0, 1'b0);
    reset_mid_burst();
    applyStimulus(64'h8000_0000, 8'd3, 0, -1, 1'b0, 1'b0);
    applyStimulus(64'h0000_1000, 8'd3, 1, -1, 1'b0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      logic [63:0] base;
      logic [7:0]  len;
      int          corrupt;
      base = {$urandom, $urandom};
      len  = 8'($urandom_range(0, 15));
      corrupt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(len) + 2)) : -1;
      applyStimulus(base, len, int'($urandom_range(0, 1)), corrupt,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
